modulo_reducer_seq: RTL and testbench
=====================================

# modulo_reducer_seq

Sequential, parametrised successor to the combinational modulo reduction block. It computes `number mod m` and `number / m` for any `WIDTH`-bit unsigned operands using restoring shift-subtract, one quotient bit per cycle. Input and output use valid/ready handshakes. It sits between operand producers and arithmetic consumers, where a fixed worst-case latency replaces a subtract-loop whose delay depends on the operand values.

## Interface
- `WIDTH`, default 32: operand, result and quotient width in bits (must be ≥ 2).
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: operands on `number` and `m` are valid.
- `in_ready`  out  1: block can accept operands (high only in IDLE).
- `number`  in  WIDTH: unsigned dividend.
- `m`  in  WIDTH: unsigned modulus.
- `out_valid`  out  1: `result`, `quotient` and `div_by_zero` are valid.
- `out_ready`  in  1: consumer accepts the output.
- `result`  out  WIDTH: `number mod m`.
- `quotient`  out  WIDTH: `number / m`, truncated.
- `div_by_zero`  out  1: the request had `m == 0`.

## Operation
- States (in `modred_pkg`): IDLE, CALC, DONE.
- IDLE: `in_ready` = 1. On `in_valid`, latch the operands and choose the next state:
  - `m == 0` -> DONE with `result` = `number`, `quotient` = all ones, `div_by_zero` = 1.
  - `number < m` (fast path) -> DONE with `result` = `number`, `quotient` = 0, `div_by_zero` = 0.
  - otherwise -> CALC with remainder `rem` = 0 (WIDTH+1 bits), dividend shift register = `number`, quotient = 0, counter = WIDTH.
- CALC, each cycle:
  - `t = {rem[WIDTH-1:0], dsr[WIDTH-1]}`; shift `dsr` left by 1.
  - If `t >= {1'b0, m}`: `rem = t - m` and shift a 1 into `quotient`; else `rem = t` and shift in 0.
  - Decrement the counter. After the cycle where the counter goes from 1 to 0, go to DONE.
  - `result` = `rem[WIDTH-1:0]`. `rem` never exceeds WIDTH bits after the subtract.
- DONE: `out_valid` = 1. Outputs stay stable while `out_ready` = 0. On `out_ready` = 1, go to IDLE and drop `out_valid` in the next cycle.
- No new request is accepted in the cycle an output is consumed; `in_ready` rises only in IDLE.
- All comparisons and subtractions are unsigned. No overflow is possible.
- `rst` in any state, including mid-CALC, aborts the operation. The next cycle is IDLE with all outputs at their reset values. The in-flight result is discarded, not emitted.

## Timing
- Reset values: `in_ready` = 1 once reset is released, `out_valid` = 0, `result` = 0, `quotient` = 0, `div_by_zero` = 0. `in_ready` = 0 while `rst` is high.
- Acceptance is the edge with `in_valid && in_ready`, called cycle 0.
- Normal path: `out_valid` goes high at cycle WIDTH+1, which is 33 for WIDTH=32.
- Fast path and `m == 0`: `out_valid` goes high at cycle 1.
- With `out_ready` held high, throughput is one operation per WIDTH+2 cycles (normal) or 2 cycles (fast path).
- Output is registered; there is no combinational path from inputs to outputs.
- `in_ready` depends only on the state, never combinationally on `in_valid`.

## Structure
- Package `modred_pkg` holds:
  - the state enum;
  - `cnt_width(WIDTH)` = `$clog2(WIDTH+1)` for the counter width.
- Sub-module `modred_step`, combinational, parameter `WIDTH`:
  - inputs: `rem_in`, `msb_in`, `m`;
  - outputs: `rem_out`, `q_bit`;
  - contains the single shift-compare-subtract step.
- Top level: FSM, counter, operand and output registers, handshake logic.

## Test plan
- WIDTH=32, `number` = 100, `m` = 7 -> `result` = 2, `quotient` = 14, `div_by_zero` = 0, `out_valid` at cycle 33.
- `number` = 5, `m` = 9 -> `result` = 5, `quotient` = 0, `out_valid` at cycle 1. Then `number` = 9, `m` = 9 -> `result` = 0, `quotient` = 1, at cycle 33.
- `m` = 0, `number` = 0x1234 -> `div_by_zero` = 1, `result` = 0x1234, `quotient` = 0xFFFFFFFF, at cycle 1.
- `number` = 0xFFFFFFFF, `m` = 1 -> `result` = 0, `quotient` = 0xFFFFFFFF. Then `m` = 0xFFFFFFFF -> `result` = 0, `quotient` = 1.
- Backpressure: hold `out_ready` = 0 for 10 cycles after `out_valid` -> outputs stable and `in_ready` = 0 throughout. Release -> IDLE next cycle.
- Assert `rst` at cycle 10 of a CALC -> next cycle `in_ready` = 1 and all outputs 0. A new request then completes correctly.
- WIDTH=8 instance, `number` = 255, `m` = 16 -> `result` = 15, `quotient` = 15, `out_valid` at cycle 9.

Source files
------------

// File: rtl/modred_pkg.sv
// Shared definitions for the sequential modulo reducer: FSM state encoding
// and the helper that sizes the bit counter.
package modred_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/modred_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the modulus when it fits, and report the quotient bit.
module modred_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             msb_in,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] w_t;
  logic [WIDTH:0] w_m_ext;

  assign w_t     = {rem_in, msb_in};
  assign w_m_ext = {1'b0, m};
  assign q_bit   = (w_t >= w_m_ext);
  // The remainder stays below m after the subtract, so WIDTH bits always hold it.
  assign rem_out = q_bit ? WIDTH'(w_t - w_m_ext) : w_t[WIDTH-1:0];

endmodule

// File: rtl/modulo_reducer_seq.sv
// Sequential number mod m / number div m using restoring shift-subtract,
// one quotient bit per cycle, with valid/ready on both sides.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// CALC    | shift-subtract, one quotient bit per cycle, WIDTH cycles
// DONE    | result held with out_valid high until out_ready
module modulo_reducer_seq
  import modred_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] number,
  input  logic [WIDTH-1:0] m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_e           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_cnt;
  logic             r_dbz;

  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;

  modred_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (r_rem),
    .msb_in  (r_dsr[WIDTH-1]),
    .m       (r_m),
    .rem_out (w_rem_next),
    .q_bit   (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_dsr   <= '0;
      r_quo   <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_m   <= m;
            r_dsr <= number;
            r_cnt <= CW'(WIDTH);
            r_dbz <= 1'b0;
            if (m == '0) begin
              r_rem   <= number;
              r_quo   <= '1;
              r_dbz   <= 1'b1;
              r_state <= ST_DONE;
            end else if (number < m) begin
              r_rem   <= number;
              r_quo   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= '0;
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_next;
          r_dsr <= {r_dsr[WIDTH-2:0], 1'b0};
          r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE) && !rst;
  assign out_valid   = (r_state == ST_DONE);
  assign result      = r_rem;
  assign quotient    = r_quo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_modulo_reducer_seq.sv
// Scoreboard bench for modulo_reducer_seq at WIDTH=32 and WIDTH=8, with a
// plain-arithmetic reference model for result, quotient, flag and latency.
module tb_modulo_reducer_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, dbz;
  logic [31:0] number, m, result, quotient;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_dbz;
  logic [7:0]  b_number, b_m, b_result, b_quotient;

  modulo_reducer_seq #(.WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .number(number), .m(m), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .quotient(quotient), .div_by_zero(dbz)
  );

  modulo_reducer_seq #(.WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .number(b_number), .m(b_m), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .result(b_result), .quotient(b_quotient), .div_by_zero(b_dbz)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] quo;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_rdy = 0;

  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [31:0] n, input logic [31:0] d, input int w);
    exp_t e;
    logic [31:0] ones;
    ones = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (d == 0) begin
      e.res = n; e.quo = ones; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.res = n % d; e.quo = n / d; e.dbz = 1'b0;
      e.lat = (n < d) ? 1 : w + 1;
    end
    e.acc = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the 32-bit instance: first valid cycle pops and compares,
  // later valid cycles must hold the outputs and keep in_ready low.
  bit          a_seen = 0;
  bit          a_expect_idle = 0;
  logic [31:0] a_hres, a_hquo;
  logic        a_hdbz;

  always @(negedge clk) begin
    exp_t e;
    if (a_expect_idle) begin
      check("a_idle_in_ready", {31'b0, in_ready}, 32'd1);
      check("a_idle_out_valid", {31'b0, out_valid}, 32'd0);
      a_expect_idle = 0;
    end
    if (out_valid) begin
      if (!a_seen) begin
        if (sb_a.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected_output result=0x%08h quotient=0x%08h", result, quotient);
        end else begin
          e = sb_a.pop_front();
          check("a_result", result, e.res);
          check("a_quotient", quotient, e.quo);
          check("a_div_by_zero", {31'b0, dbz}, {31'b0, e.dbz});
          check("a_latency", cyc - e.acc + 1, e.lat);
        end
        a_hres = result; a_hquo = quotient; a_hdbz = dbz;
        a_seen = 1;
      end else begin
        check("a_hold_result", result, a_hres);
        check("a_hold_quotient", quotient, a_hquo);
        check("a_hold_dbz", {31'b0, dbz}, {31'b0, a_hdbz});
        check("a_busy_in_ready", {31'b0, in_ready}, 32'd0);
      end
      if (out_ready) begin
        a_seen = 0;
        a_expect_idle = 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_out_valid && b_out_ready) begin
      if (sb_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_output result=0x%02h quotient=0x%02h", b_result, b_quotient);
      end else begin
        e = sb_b.pop_front();
        check("b_result", {24'b0, b_result}, e.res);
        check("b_quotient", {24'b0, b_quotient}, e.quo);
        check("b_div_by_zero", {31'b0, b_dbz}, {31'b0, e.dbz});
        check("b_latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_a(input logic [31:0] n, input logic [31:0] d);
    exp_t e;
    int   budget;
    @(negedge clk);
    in_valid = 1'b1; number = n; m = d;
    budget = 0;
    while (!in_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL a_accept_timeout in_ready=%0b required=1", in_ready);
      in_valid = 1'b0;
    end else begin
      e = model(n, d, 32);
      e.acc = cyc + 1;
      sb_a.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0; number = $urandom; m = $urandom;
    end
  endtask

  task automatic send_b(input logic [7:0] n, input logic [7:0] d);
    exp_t e;
    int   budget;
    @(negedge clk);
    b_in_valid = 1'b1; b_number = n; b_m = d;
    budget = 0;
    while (!b_in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!b_in_ready) begin
      errors++;
      $display("FAIL b_accept_timeout in_ready=%0b required=1", b_in_ready);
      b_in_valid = 1'b0;
    end else begin
      e = model({24'b0, n}, {24'b0, d}, 8);
      e.acc = cyc + 1;
      sb_b.push_back(e);
      @(posedge clk);
      #1 b_in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int budget = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0 || out_valid || b_out_valid) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout pending_a=%0d pending_b=%0d required=0", name, sb_a.size(), sb_b.size());
      sb_a.delete(); sb_b.delete();
    end
  endtask

  function automatic logic [31:0] rand_m(input logic [31:0] n);
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'($urandom_range(1, 20));
      2: return n;
      3: return n >> $urandom_range(1, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int budget;
    int acc;
    rst = 1'b1;
    in_valid = 1'b0; number = '0; m = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_number = '0; b_m = '0; b_out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_dbz", {31'b0, dbz}, 32'd0);
    check("reset_b_in_ready", {31'b0, b_in_ready}, 32'd1);

    send_a(32'd100, 32'd7);
    send_a(32'd5, 32'd9);
    send_a(32'd9, 32'd9);
    send_a(32'h1234, 32'd0);
    send_a(32'hFFFF_FFFF, 32'd1);
    send_a(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain("directed");

    // Backpressure: hold the consumer off for 10 cycles once the result appears.
    out_ready = 1'b0;
    send_a(32'd1000, 32'd3);
    budget = 0;
    while (!out_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("bp_out_valid_seen", {31'b0, out_valid}, 32'd1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain("backpressure");

    // Reset ten cycles into a CALC; the in-flight result must never appear.
    send_a(32'hDEAD_BEEF, 32'd13);
    acc = cyc;
    while (cyc < acc + 9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb_a.delete();
    a_seen = 0;
    a_expect_idle = 0;
    @(negedge clk);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_dbz", {31'b0, dbz}, 32'd0);
    repeat (40) @(negedge clk);
    check("abort_no_output", {31'b0, out_valid}, 32'd0);
    send_a(32'd100, 32'd7);
    drain("after_abort");

    send_b(8'd255, 8'd16);
    send_b(8'd3, 8'd0);
    send_b(8'd7, 8'd200);
    send_b(8'd200, 8'd200);
    drain("width8");

    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] n;
      n = $urandom;
      if ($urandom_range(0, 3) == 0) n = 32'($urandom_range(0, 50));
      send_a(n, rand_m(n));
    end
    for (int i = 0; i < 20; i++) begin
      logic [7:0] bn;
      logic [7:0] bd;
      bn = 8'($urandom);
      bd = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
      send_b(bn, bd);
    end
    drain("random");
    rand_rdy = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
